// File: rtl/zspi_pkg.sv
`timescale 1ns/1ps
// Shared constants for the Zorro II SPI master: register map, AutoConfig ROM, engine states.
// Latency: none (definitions only).
// Backpressure: none.
package zspi_pkg;

    localparam logic [7:0] CFG_PAGE = 8'hE8;

    // Word indices (A[6:1]) of the board registers
    localparam logic [5:0] REG_DATA   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_CS     = 6'h02;
    localparam logic [5:0] REG_DIV    = 6'h03;
    localparam logic [5:0] REG_CTRL   = 6'h04;

    // Word indices of the AutoConfig write registers (byte offsets 0x48/0x4A/0x4C)
    localparam logic [5:0] CFG_BASE_HI = 6'h24;
    localparam logic [5:0] CFG_BASE_LO = 6'h25;
    localparam logic [5:0] CFG_SHUTUP  = 6'h26;

    typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_DONE} spi_state_t;

    // AutoConfig ROM nibble, indexed by byte offset >> 1
    function automatic logic [3:0] rom_nibble(input logic [5:0] idx);
        logic [3:0] n;
        case (idx)
            6'h00:   n = 4'hC;
            6'h01:   n = 4'h1;
            6'h02:   n = 4'h7;
            6'h03:   n = 4'hE;
            6'h04:   n = 4'h7;
            6'h08:   n = 4'hE;
            6'h09:   n = 4'hC;
            6'h0A:   n = 4'h2;
            6'h0B:   n = 4'h7;
            6'h11:   n = 4'hD;
            6'h12:   n = 4'hE;
            6'h13:   n = 4'hD;
            default: n = 4'hF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/zspi_shift.sv
`timescale 1ns/1ps
// SPI byte engine: SCK divider, edge generator and MSB-first shift register.
// Latency: 17*(div+1) CLK from start to busy low, then one DONE cycle.
// Backpressure: start is only honoured in IDLE/DONE; caller gates it with busy.
module zspi_shift
    import zspi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       tx,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             miso,
    output logic             busy,
    output logic [7:0]       rx,
    output logic             sck,
    output logic             mosi
);

    spi_state_t       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic             cpol_q;
    logic             cpha_q;
    logic [4:0]       ec;
    logic [4:0]       edge_n;
    logic [7:0]       sr;

    // Edge number (1..16) that fires at the end of the current half-period
    assign edge_n = ec + 5'd1;

    // Engine FSM: LEAD half-period, 16 SCK edges plus a closing half-period, one DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            div_q  <= '1;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            ec     <= '0;
            sr     <= '0;
            rx     <= '0;
            busy   <= 1'b0;
            sck    <= 1'b0;
            mosi   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    sck   <= cpol;
                    state <= ST_IDLE;
                    if (start) begin
                        state  <= ST_LEAD;
                        busy   <= 1'b1;
                        div_q  <= div;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        sr     <= tx;
                        cnt    <= '0;
                        ec     <= '0;
                        if (!cpha) mosi <= tx[7];
                    end
                end
                default: begin
                    if (cnt != div_q) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (state == ST_SHIFT && ec == 5'd16) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            rx    <= sr;
                        end else begin
                            state <= ST_SHIFT;
                            sck   <= ~sck;
                            ec    <= edge_n;
                            // Odd edges lead; CPHA picks whether leading edges sample or shift
                            if (edge_n[0] ^ cpha_q)
                                sr <= {sr[6:0], miso};
                            else if (edge_n != 5'd16)
                                mosi <= sr[7];
                        end
                    end
                end
            endcase
        end
    end

    logic unused_cpol_q;
    assign unused_cpol_q = cpol_q;

endmodule

// File: rtl/zspi_master.sv
`timescale 1ns/1ps
// Zorro II SPI master: AutoConfig at $E8, 64 KB register window, one SPI byte engine.
// Latency: register action on the CLK after synced DS20 falls; DOUT valid one CLK later.
// Backpressure: DATA writes while busy are dropped and flagged in STATUS.OVR.
module zspi_master
    import zspi_pkg::*;
#(
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [23:1]       A,
    input  logic [7:0]        D,
    output logic [7:0]        DOUT,
    output logic              ACCESS,
    input  logic              AS20,
    input  logic              DS20,
    input  logic              RW20,
    input  logic              CFG_IN,
    output logic              CFG_OUT,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic [NUM_CS-1:0] SPI_CS
);

    logic [1:0]        as_s, ds_s;
    logic              as_d, ds_d;
    logic              ds_fall, as_rise;
    logic [7:0]        base;
    logic              configured, shutup;
    logic [NUM_CS-1:0] cs_reg;
    logic [DIV_W-1:0]  div_reg;
    logic              cpol, cpha, ovr;
    logic              busy;
    logic [7:0]        rx;
    logic              cfg_hit, brd_hit, start;
    logic [5:0]        sel;
    logic [7:0]        cs_rd;
    logic              unused_a;

    assign unused_a = ^A[15:7];
    assign sel      = A[6:1];
    assign ds_fall  = ds_d & ~ds_s[1];
    assign as_rise  = ~as_d & as_s[1];
    assign cfg_hit  = (A[23:16] == CFG_PAGE) && !as_s[1] && CFG_IN && !CFG_OUT;
    assign brd_hit  = !cfg_hit && (A[23:16] == base) && !as_s[1] && configured && !shutup;
    assign ACCESS   = !(cfg_hit || brd_hit);
    assign start    = ds_fall && brd_hit && !RW20 && (sel == REG_DATA) && !busy;
    assign SPI_CS   = cs_reg;

    // CS readback: unused select bits read as 1
    always_comb begin
        cs_rd = 8'hFF;
        cs_rd[NUM_CS-1:0] = cs_reg;
    end

    // Two-flop synchronisers for the bus strobes plus edge-detect history
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            as_s <= 2'b11;
            ds_s <= 2'b11;
            as_d <= 1'b1;
            ds_d <= 1'b1;
        end else begin
            as_s <= {as_s[0], AS20};
            ds_s <= {ds_s[0], DS20};
            as_d <= as_s[1];
            ds_d <= ds_s[1];
        end
    end

    // AutoConfig state and board registers; one action per ds_fall
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            base       <= '0;
            configured <= 1'b0;
            shutup     <= 1'b0;
            CFG_OUT    <= 1'b0;
            cs_reg     <= '1;
            div_reg    <= '1;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            ovr        <= 1'b0;
            DOUT       <= 8'hFF;
        end else begin
            if ((configured || shutup) && as_rise) CFG_OUT <= 1'b1;
            if (ds_fall && cfg_hit) begin
                if (RW20) begin
                    DOUT <= {rom_nibble(sel), 4'hF};
                end else begin
                    case (sel)
                        CFG_BASE_HI: begin
                            base[7:4]  <= D[7:4];
                            configured <= 1'b1;
                        end
                        CFG_BASE_LO: base[3:0] <= D[7:4];
                        CFG_SHUTUP:  shutup    <= 1'b1;
                        default: ;
                    endcase
                end
            end else if (ds_fall && brd_hit) begin
                if (RW20) begin
                    case (sel)
                        REG_DATA:   DOUT <= rx;
                        REG_STATUS: begin
                            DOUT <= {6'b0, ovr, busy};
                            ovr  <= 1'b0;
                        end
                        REG_CS:     DOUT <= cs_rd;
                        REG_DIV:    DOUT <= 8'(div_reg);
                        REG_CTRL:   DOUT <= {6'b0, cpha, cpol};
                        default:    DOUT <= 8'hFF;
                    endcase
                end else begin
                    case (sel)
                        REG_DATA: if (busy) ovr <= 1'b1;
                        REG_CS:   cs_reg  <= D[NUM_CS-1:0];
                        REG_DIV:  div_reg <= DIV_W'(D);
                        REG_CTRL: {cpha, cpol} <= D[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    zspi_shift #(.DIV_W(DIV_W)) u_shift (
        .clk   (CLK),
        .rst_n (RESET),
        .start (start),
        .tx    (D),
        .div   (div_reg),
        .cpol  (cpol),
        .cpha  (cpha),
        .miso  (SPI_MISO),
        .busy  (busy),
        .rx    (rx),
        .sck   (SPI_CLK),
        .mosi  (SPI_MOSI)
    );

endmodule

// File: tb/tb_zspi_master.sv
`timescale 1ns/1ps
// Bench for zspi_master: bus-cycle tasks, SPI slave model and RX/MOSI scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_zspi_master;

    localparam int NUM_CS = 2;
    localparam int DIV_W  = 8;
    localparam logic [23:0] BASE = 24'h400000;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [23:1]       A;
    logic [7:0]        D;
    logic [7:0]        DOUT;
    logic              ACCESS, AS20, DS20, RW20, CFG_IN, CFG_OUT;
    logic              SPI_CLK, SPI_MOSI, SPI_MISO;
    logic [NUM_CS-1:0] SPI_CS;

    zspi_master #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .CLK(CLK), .RESET(RESET), .A(A), .D(D), .DOUT(DOUT), .ACCESS(ACCESS),
        .AS20(AS20), .DS20(DS20), .RW20(RW20), .CFG_IN(CFG_IN), .CFG_OUT(CFG_OUT),
        .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_CS(SPI_CS)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Slave model and scoreboards
    bit          loop = 1'b0;
    bit          m_cpol = 1'b0;
    bit          m_cpha = 1'b0;
    logic [7:0]  s_byte = 8'h3C;
    logic [7:0]  s_sh = 8'hFF;
    logic [7:0]  s_rx = 8'h00;
    int          s_bits = 0;
    logic        s_miso = 1'b1;
    logic [7:0]  mosi_q[$];
    logic [7:0]  rx_q[$];

    assign SPI_MISO = loop ? SPI_MOSI : s_miso;

    task automatic present();
        s_miso = s_sh[7];
        s_sh   = {s_sh[6:0], 1'b1};
    endtask

    task automatic slave_init();
        s_bits = 0;
        s_sh   = s_byte;
        if (!m_cpha) present();
    endtask

    always @(SPI_CLK) begin
        if (SPI_CS[0] === 1'b0) begin
            if ((SPI_CLK !== m_cpol) ^ m_cpha) begin
                s_rx = {s_rx[6:0], SPI_MOSI};
                s_bits++;
                if (s_bits == 8) begin
                    if (mosi_q.size() == 0) check("slave_unexpected_byte", 32'(s_rx), 32'h100);
                    else check("slave_mosi", 32'(s_rx), 32'(mosi_q.pop_front()));
                    s_bits = 0;
                    s_sh   = s_byte;
                    if (!m_cpha) present();
                end
            end else if (m_cpha || s_bits != 0) begin
                present();
            end
        end
    end

    // Cycle-level monitors: busy run length and SCK period in CLK cycles
    int cyc = 0, busy_run = 0, busy_len = 0, last_rise = 0, sck_per = 0;
    always @(posedge CLK) cyc++;
    always @(negedge CLK) begin
        if (dut.u_shift.busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end
    always @(posedge SPI_CLK) begin
        sck_per   = cyc - last_rise;
        last_rise = cyc;
    end

    task automatic set_addr(input logic [23:0] addr);
        A = addr[23:1];
    endtask

    task automatic bus_write(input logic [23:0] addr, input logic [7:0] dat);
        @(posedge CLK); #1;
        set_addr(addr); D = dat; RW20 = 1'b0; AS20 = 1'b0;
        @(posedge CLK); #1;
        DS20 = 1'b0;
        repeat (4) @(posedge CLK);
        #1; DS20 = 1'b1; AS20 = 1'b1; RW20 = 1'b1;
        repeat (3) @(posedge CLK);
    endtask

    task automatic bus_read(input logic [23:0] addr, output logic [7:0] dat);
        @(posedge CLK); #1;
        set_addr(addr); RW20 = 1'b1; AS20 = 1'b0;
        @(posedge CLK); #1;
        DS20 = 1'b0;
        repeat (4) @(posedge CLK);
        #1; dat = DOUT; DS20 = 1'b1; AS20 = 1'b1;
        repeat (3) @(posedge CLK);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dut.u_shift.busy !== 1'b0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic read_rx();
        logic [7:0] r;
        bus_read(BASE + 24'h0, r);
        if (rx_q.size() == 0) check("rx_queue_empty", 32'd1, 32'd0);
        else check("rx_data", 32'(r), 32'(rx_q.pop_front()));
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input logic [7:0] exp_rx);
        mosi_q.push_back(tx);
        rx_q.push_back(exp_rx);
        bus_write(BASE + 24'h0, tx);
        wait_idle();
        read_rx();
    endtask

    task automatic set_mode(input bit cpol, input bit cpha);
        bus_write(BASE + 24'h4, 8'hFF);
        m_cpol = cpol;
        m_cpha = cpha;
        bus_write(BASE + 24'h8, {6'b0, cpha, cpol});
        slave_init();
        bus_write(BASE + 24'h4, 8'hFE);
    endtask

    initial begin
        logic [7:0] r;
        A = '0; D = '0; AS20 = 1'b1; DS20 = 1'b1; RW20 = 1'b1; CFG_IN = 1'b1;
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_dout", 32'(DOUT), 32'hFF);
        check("rst_access", 32'(ACCESS), 32'd1);
        check("rst_cfg_out", 32'(CFG_OUT), 32'd0);
        check("rst_sck", 32'(SPI_CLK), 32'd0);
        check("rst_mosi", 32'(SPI_MOSI), 32'd1);
        check("rst_cs", 32'(SPI_CS), 32'h3);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // AutoConfig ROM and base assignment
        bus_read(24'hE80000, r); check("rom_00", 32'(r), 32'hCF);
        bus_read(24'hE80002, r); check("rom_02", 32'(r), 32'h1F);
        bus_read(24'hE80004, r); check("rom_04", 32'(r), 32'h7F);
        bus_read(24'hE80026, r); check("rom_26", 32'(r), 32'hDF);
        bus_read(24'hE8000A, r); check("rom_0a", 32'(r), 32'hFF);
        bus_write(24'hE80048, 8'h40);
        bus_write(24'hE8004A, 8'h00);
        @(negedge CLK);
        check("cfg_out_set", 32'(CFG_OUT), 32'd1);
        set_addr(24'hE80000); AS20 = 1'b0;
        repeat (3) @(negedge CLK);
        check("cfg_window_dead", 32'(ACCESS), 32'd1);
        set_addr(BASE);
        @(negedge CLK);
        check("board_access", 32'(ACCESS), 32'd0);
        AS20 = 1'b1;
        repeat (3) @(posedge CLK);

        // Register reset values and decode
        bus_read(BASE + 24'h6, r); check("div_reset", 32'(r), 32'hFF);
        bus_read(BASE + 24'h8, r); check("ctrl_reset", 32'(r), 32'h00);
        bus_read(BASE + 24'hA, r); check("unmapped", 32'(r), 32'hFF);
        bus_read(BASE + 24'h2, r); check("status_idle", 32'(r), 32'h00);

        // Mode 0, DIV=0, loopback
        bus_write(BASE + 24'h4, 8'hFE);
        bus_write(BASE + 24'h6, 8'h00);
        bus_read(BASE + 24'h84, r); check("cs_mirror", 32'(r), 32'hFE);
        check("cs_pins", 32'(SPI_CS), 32'h2);
        loop = 1'b1; m_cpol = 1'b0; m_cpha = 1'b0; slave_init();
        spi_xfer(8'hA5, 8'hA5);
        // ds_fall cycle plus 17 busy cycles makes the 18-cycle transfer
        check("busy_len_div0", 32'(busy_len), 32'd17);
        check("sck_idle_m0", 32'(SPI_CLK), 32'd0);
        check("cs_held", 32'(SPI_CS), 32'h2);
        loop = 1'b0;

        // Modes 1..3 with slave returning 3C
        for (int m = 1; m < 4; m++) begin
            logic [7:0] tx;
            tx = 8'h96 ^ 8'(m * 8'h21);
            set_mode(m[1], m[0]);
            check("sck_idle_before", 32'(SPI_CLK), 32'(m[1]));
            spi_xfer(tx, 8'h3C);
            check("sck_idle_after", 32'(SPI_CLK), 32'(m[1]));
        end

        // Overrun: second DATA write dropped, OVR read-to-clear
        set_mode(1'b0, 1'b0);
        bus_write(BASE + 24'h6, 8'h01);
        mosi_q.push_back(8'h5A);
        rx_q.push_back(8'h3C);
        bus_write(BASE + 24'h0, 8'h5A);
        bus_write(BASE + 24'h0, 8'hC3);
        bus_read(BASE + 24'h2, r); check("ovr_set", 32'(r[1]), 32'd1);
        bus_read(BASE + 24'h2, r); check("ovr_clear", 32'(r[1]), 32'd0);
        wait_idle();
        read_rx();

        // DIV changed mid-transfer: current byte keeps DIV=1, next uses DIV=3
        mosi_q.push_back(8'h11);
        rx_q.push_back(8'h3C);
        bus_write(BASE + 24'h0, 8'h11);
        bus_write(BASE + 24'h6, 8'h03);
        wait_idle();
        read_rx();
        check("sck_period_old", 32'(sck_per), 32'd4);
        spi_xfer(8'h22, 8'h3C);
        check("sck_period_new", 32'(sck_per), 32'd8);
        check("busy_len_div3", 32'(busy_len), 32'd68);

        // Reset during bit 4 aborts everything
        begin
            int n = 0;
            bus_write(BASE + 24'h0, 8'hF0);
            while (s_bits != 4 && n < 2000) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 2000) check("bit4_timeout", 32'd1, 32'd0);
        end
        #2 RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        mosi_q.delete();
        rx_q.delete();
        slave_init();
        @(negedge CLK);
        check("abort_cs", 32'(SPI_CS), 32'h3);
        check("abort_sck", 32'(SPI_CLK), 32'd0);
        check("abort_mosi", 32'(SPI_MOSI), 32'd1);
        check("abort_busy", 32'(dut.u_shift.busy), 32'd0);
        check("abort_cfg_out", 32'(CFG_OUT), 32'd0);
        check("abort_dout", 32'(DOUT), 32'hFF);
        bus_read(24'hE80000, r); check("abort_rom_00", 32'(r), 32'hCF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
